// File: rtl/tych_ing_pkg.sv
// Shared types and default widths for the MAC-RX to core ingress converter.
package tych_ing_pkg;

  localparam int unsigned M2C_DATA_W  = 512;
  localparam int unsigned M2C_EMPTY_W = 6;
  localparam int unsigned M2C_ERR_W   = 6;
  localparam int unsigned M2C_ID_W    = 12;
  localparam int unsigned STAT_W      = 32;

  typedef enum logic [1:0] {
    IDLE,
    IN_FRAME,
    DROP
  } m2c_state_e;

  typedef struct packed {
    logic [M2C_DATA_W-1:0]  data;
    logic                   sop;
    logic                   eop;
    logic [M2C_EMPTY_W-1:0] empty;
    logic                   error;
    logic [M2C_ID_W-1:0]    frm_id;
  } m2c_beat_t;

endpackage

// File: rtl/tych_sync_fifo.sv
// Generic show-ahead synchronous FIFO; DEPTH must be a power of 2.
module tych_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             push_ok, pop_ok;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  // A push into a full FIFO is accepted when the head leaves in the same cycle.
  assign push_ok = push_i && (!full_o || pop_i);
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_q + LW'(push_ok) - LW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/tych_ing_m2c_fifo.sv
// MAC-RX to core valid/ready ingress converter with framing repair, frame IDs and output FIFO.
// Optional statistics counters are built when TYCH_ING_M2C_STATS_EN is defined.
module tych_ing_m2c_fifo
  import tych_ing_pkg::*;
#(
  parameter int unsigned DATA_W  = M2C_DATA_W,
  parameter int unsigned EMPTY_W = M2C_EMPTY_W,
  parameter int unsigned ERR_W   = M2C_ERR_W,
  parameter int unsigned ID_W    = M2C_ID_W,
  parameter int unsigned DEPTH   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      in_sop,
  input  logic                      in_eop,
  input  logic [EMPTY_W-1:0]        in_empty,
  input  logic [ERR_W-1:0]          in_errors,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_sop,
  output logic                      out_eop,
  output logic [EMPTY_W-1:0]        out_empty,
  output logic                      out_error,
  output logic [ID_W-1:0]           out_frm_id,
  output logic [$clog2(DEPTH):0]    fifo_level,
  output logic                      ovf_pulse,
  output logic [STAT_W-1:0]         stat_ok,
  output logic [STAT_W-1:0]         stat_err,
  output logic [STAT_W-1:0]         stat_drop,
  output logic [STAT_W-1:0]         stat_orphan
);

  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  m2c_state_e      state_q, state_d;
  logic            acc_q, acc_d;
  logic [ID_W-1:0] id_q, id_d;
  logic            ovf_q, ovf_c;
  logic            wr_en_c;
  m2c_beat_t       wr_beat_c, rd_beat;
  logic [LVL_W-1:0] level;
  logic            fifo_full, fifo_empty;
  logic            free1, free2, beat_err;

  assign beat_err = |in_errors;
  assign free1    = !fifo_full;
  assign free2    = (level <= LVL_W'(DEPTH - 2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Framing FSM and write-beat formation; only MAC valid beats advance it.
  always_comb begin
    state_d          = state_q;
    acc_d            = acc_q;
    id_d             = id_q;
    wr_en_c          = 1'b0;
    ovf_c            = 1'b0;
    wr_beat_c.data   = M2C_DATA_W'(in_data);
    wr_beat_c.sop    = in_sop;
    wr_beat_c.eop    = in_eop;
    wr_beat_c.empty  = in_eop ? M2C_EMPTY_W'(in_empty) : '0;
    wr_beat_c.error  = beat_err;
    wr_beat_c.frm_id = M2C_ID_W'(id_q);
    if (in_valid) begin
      unique case (state_q)
        IDLE: begin
          if (in_sop && in_eop) begin
            if (free1) wr_en_c = 1'b1;
            else       ovf_c   = 1'b1;
          end else if (in_sop) begin
            if (free2) begin
              wr_en_c = 1'b1;
              acc_d   = beat_err;
              state_d = IN_FRAME;
            end else begin
              ovf_c   = 1'b1;
              state_d = DROP;
            end
          end
        end
        IN_FRAME: begin
          wr_en_c = 1'b1;
          if (in_sop) begin
            // Missing eop: this beat closes the old frame; a single-beat new frame ends here too.
            wr_beat_c.sop   = 1'b0;
            wr_beat_c.eop   = 1'b1;
            wr_beat_c.error = 1'b1;
            wr_beat_c.empty = '0;
            state_d         = in_eop ? IDLE : DROP;
          end else if (in_eop) begin
            wr_beat_c.error = beat_err | acc_q;
            state_d         = IDLE;
          end else if (free2) begin
            acc_d = acc_q | beat_err;
          end else begin
            wr_beat_c.eop   = 1'b1;
            wr_beat_c.error = 1'b1;
            wr_beat_c.empty = '0;
            ovf_c           = 1'b1;
            state_d         = DROP;
          end
        end
        DROP: begin
          if (in_eop) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    if (wr_en_c && wr_beat_c.eop) begin
      id_d  = id_q + ID_W'(1);
      acc_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= 1'b0;
      id_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      id_q  <= id_d;
      ovf_q <= ovf_c;
    end
  end

  tych_sync_fifo #(
    .WIDTH ($bits(m2c_beat_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (wr_en_c),
    .wdata_i (wr_beat_c),
    .pop_i   (out_ready),
    .rdata_o (rd_beat),
    .level_o (level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign out_valid  = !fifo_empty;
  assign out_data   = DATA_W'(rd_beat.data);
  assign out_sop    = rd_beat.sop;
  assign out_eop    = rd_beat.eop;
  assign out_empty  = EMPTY_W'(rd_beat.empty);
  assign out_error  = rd_beat.error;
  assign out_frm_id = ID_W'(rd_beat.frm_id);
  assign fifo_level = level;
  assign ovf_pulse  = ovf_q;

`ifdef TYCH_ING_M2C_STATS_EN
  logic [STAT_W-1:0] ok_q, err_q, drop_q, orphan_q;
  logic              ok_ev, err_ev, drop_ev, orphan_ev;

  assign ok_ev     = wr_en_c && wr_beat_c.eop && !wr_beat_c.error;
  assign err_ev    = wr_en_c && wr_beat_c.eop && wr_beat_c.error;
  assign drop_ev   = in_valid && (state_q == IDLE) && in_sop && !wr_en_c;
  assign orphan_ev = in_valid && (state_q == IDLE) && !in_sop;

  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ok_q     <= '0;
      err_q    <= '0;
      drop_q   <= '0;
      orphan_q <= '0;
    end else begin
      if (ok_ev     && (ok_q     != '1)) ok_q     <= ok_q     + STAT_W'(1);
      if (err_ev    && (err_q    != '1)) err_q    <= err_q    + STAT_W'(1);
      if (drop_ev   && (drop_q   != '1)) drop_q   <= drop_q   + STAT_W'(1);
      if (orphan_ev && (orphan_q != '1)) orphan_q <= orphan_q + STAT_W'(1);
    end
  end

  assign stat_ok     = ok_q;
  assign stat_err    = err_q;
  assign stat_drop   = drop_q;
  assign stat_orphan = orphan_q;
`else
  assign stat_ok     = '0;
  assign stat_err    = '0;
  assign stat_drop   = '0;
  assign stat_orphan = '0;
`endif

endmodule

// File: tb/tb_tych_ing_m2c_fifo.sv
// Directed self-checking bench for tych_ing_m2c_fifo (DEPTH=8).
module tb_tych_ing_m2c_fifo;

  logic          clk, rst_n;
  logic          in_valid, in_sop, in_eop;
  logic [511:0]  in_data;
  logic [5:0]    in_empty, in_errors;
  logic          out_valid, out_ready, out_sop, out_eop, out_error;
  logic [511:0]  out_data;
  logic [5:0]    out_empty;
  logic [11:0]   out_frm_id;
  logic [3:0]    fifo_level;
  logic          ovf_pulse;
  logic [31:0]   stat_ok, stat_err, stat_drop, stat_orphan;

  int checks = 0;
  int errors = 0;
  int ovf_cnt;

  tych_ing_m2c_fifo #(.DEPTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_sop      (in_sop),
    .in_eop      (in_eop),
    .in_empty    (in_empty),
    .in_errors   (in_errors),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_sop     (out_sop),
    .out_eop     (out_eop),
    .out_empty   (out_empty),
    .out_error   (out_error),
    .out_frm_id  (out_frm_id),
    .fifo_level  (fifo_level),
    .ovf_pulse   (ovf_pulse),
    .stat_ok     (stat_ok),
    .stat_err    (stat_err),
    .stat_drop   (stat_drop),
    .stat_orphan (stat_orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [63:0] se(input int v);
`ifdef TYCH_ING_M2C_STATS_EN
    return 64'(v);
`else
    return 64'(0 * v);
`endif
  endfunction

  task automatic send(input logic sop, input logic eop, input int emp, input int err, input int d);
    in_valid  = 1'b1;
    in_sop    = sop;
    in_eop    = eop;
    in_empty  = 6'(emp);
    in_errors = 6'(err);
    in_data   = 512'(d);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_sop    = 1'b0;
    in_eop    = 1'b0;
    in_empty  = '0;
    in_errors = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    in_data = '0; in_empty = '0; in_errors = '0; out_ready = 1'b0;
    idle(2);
    check("rst_valid", 64'(out_valid), 64'h0);
    check("rst_level", 64'(fifo_level), 64'h0);
    check("rst_ovf", 64'(ovf_pulse), 64'h0);
    check("rst_stats", 64'(stat_ok | stat_err | stat_drop | stat_orphan), 64'h0);
    @(negedge clk) rst_n = 1'b1;
    idle(1);

    // 3-beat clean frame, then a single-beat frame
    out_ready = 1'b1;
    send(1'b1, 1'b0, 0, 0, 'h11);
    check("t1_v0", 64'(out_valid), 64'h1);
    check("t1_d0", out_data[63:0], 64'h11);
    check("t1_sop0", 64'(out_sop), 64'h1);
    check("t1_id0", 64'(out_frm_id), 64'h0);
    check("t1_err0", 64'(out_error), 64'h0);
    send(1'b0, 1'b0, 0, 0, 'h12);
    check("t1_d1", out_data[63:0], 64'h12);
    check("t1_sop1", 64'(out_sop), 64'h0);
    check("t1_eop1", 64'(out_eop), 64'h0);
    send(1'b0, 1'b1, 5, 0, 'h13);
    check("t1_eop2", 64'(out_eop), 64'h1);
    check("t1_empty2", 64'(out_empty), 64'h5);
    check("t1_err2", 64'(out_error), 64'h0);
    check("t1_id2", 64'(out_frm_id), 64'h0);
    idle(1);
    check("t1_drained", 64'(out_valid), 64'h0);
    send(1'b1, 1'b1, 2, 0, 'h21);
    check("t1b_id", 64'(out_frm_id), 64'h1);
    check("t1b_empty", 64'(out_empty), 64'h2);
    idle(1);

    // error on beat 2 of a 4-beat frame
    send(1'b1, 1'b0, 0, 0, 'h31);
    check("t2_err1", 64'(out_error), 64'h0);
    send(1'b0, 1'b0, 0, 'h04, 'h32);
    check("t2_err2", 64'(out_error), 64'h1);
    send(1'b0, 1'b0, 0, 0, 'h33);
    check("t2_err3", 64'(out_error), 64'h0);
    send(1'b0, 1'b1, 0, 0, 'h34);
    check("t2_err4", 64'(out_error), 64'h1);
    check("t2_id", 64'(out_frm_id), 64'h2);
    idle(1);
    check("t2_stat_err", 64'(stat_err), se(1));
    check("t2_stat_ok", 64'(stat_ok), se(2));

    // 10-beat frame into a stalled 8-deep FIFO
    out_ready = 1'b0;
    ovf_cnt = 0;
    for (int i = 1; i <= 10; i++) begin
      send(i == 1, i == 10, 0, 0, i);
      ovf_cnt += int'(ovf_pulse);
    end
    idle(1);
    ovf_cnt += int'(ovf_pulse);
    check("t3_ovf_cnt", 64'(ovf_cnt), 64'h1);
    check("t3_level", 64'(fifo_level), 64'h8);
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check("t3_data", out_data[63:0], 64'(i));
      check("t3_eop", 64'(out_eop), 64'(i == 8));
      check("t3_err", 64'(out_error), 64'(i == 8));
      check("t3_id", 64'(out_frm_id), 64'h3);
      idle(1);
    end
    check("t3_drained", 64'(out_valid), 64'h0);
    send(1'b1, 1'b1, 0, 0, 'h41);
    check("t3_next_id", 64'(out_frm_id), 64'h4);
    check("t3_next_err", 64'(out_error), 64'h0);
    idle(1);

    // full FIFO: a single-beat frame is dropped and consumes no ID
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(1'b1, 1'b1, 0, 0, 'h50 + i);
    check("tf_level_full", 64'(fifo_level), 64'h8);
    send(1'b1, 1'b1, 0, 0, 'h5f);
    check("tf_ovf", 64'(ovf_pulse), 64'h1);
    check("tf_level_hold", 64'(fifo_level), 64'h8);
    idle(1);
    check("tf_ovf_1cyc", 64'(ovf_pulse), 64'h0);
    check("tf_stat_drop", 64'(stat_drop), se(1));
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("tf_id", 64'(out_frm_id), 64'(5 + i));
      check("tf_data", out_data[63:0], 64'('h50 + i));
      idle(1);
    end
    check("tf_drained", 64'(out_valid), 64'h0);

    // sop inside an open frame
    send(1'b1, 1'b0, 0, 0, 'h61);
    check("t4_id0", 64'(out_frm_id), 64'hd);
    send(1'b0, 1'b0, 0, 0, 'h62);
    send(1'b1, 1'b0, 3, 0, 'h63);
    check("t4_term_data", out_data[63:0], 64'h63);
    check("t4_term_sop", 64'(out_sop), 64'h0);
    check("t4_term_eop", 64'(out_eop), 64'h1);
    check("t4_term_err", 64'(out_error), 64'h1);
    check("t4_term_empty", 64'(out_empty), 64'h0);
    send(1'b0, 1'b0, 0, 0, 'h64);
    check("t4_drop_mid", 64'(out_valid), 64'h0);
    send(1'b0, 1'b1, 0, 0, 'h65);
    check("t4_drop_eop", 64'(out_valid), 64'h0);
    send(1'b1, 1'b0, 0, 0, 'h71);
    check("t4_clean_id", 64'(out_frm_id), 64'he);
    check("t4_clean_sop", 64'(out_sop), 64'h1);
    send(1'b0, 1'b1, 1, 0, 'h72);
    check("t4_clean_err", 64'(out_error), 64'h0);
    check("t4_clean_empty", 64'(out_empty), 64'h1);
    idle(1);
    check("t4_stat_err", 64'(stat_err), se(3));
    check("t4_stat_ok", 64'(stat_ok), se(12));

    // orphan beat in IDLE
    send(1'b0, 1'b0, 0, 0, 'h81);
    check("t5_valid", 64'(out_valid), 64'h0);
    check("t5_level", 64'(fifo_level), 64'h0);
    check("t5_orphan", 64'(stat_orphan), se(1));

    // reset mid-frame with 3 beats buffered
    out_ready = 1'b0;
    send(1'b1, 1'b0, 0, 0, 'h91);
    send(1'b0, 1'b0, 0, 0, 'h92);
    send(1'b0, 1'b0, 0, 0, 'h93);
    check("t6_level_pre", 64'(fifo_level), 64'h3);
    rst_n = 1'b0;
    #1;
    check("t6_valid_rst", 64'(out_valid), 64'h0);
    check("t6_level_rst", 64'(fifo_level), 64'h0);
    check("t6_stat_rst", 64'(stat_ok), 64'h0);
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b1;
    idle(1);
    send(1'b1, 1'b0, 0, 0, 'ha1);
    check("t6_sop", 64'(out_sop), 64'h1);
    check("t6_id", 64'(out_frm_id), 64'h0);
    check("t6_data", out_data[63:0], 64'ha1);
    send(1'b0, 1'b1, 4, 0, 'ha2);
    check("t6_eop", 64'(out_eop), 64'h1);
    check("t6_empty", 64'(out_empty), 64'h4);
    idle(1);
    check("t6_stat_ok", 64'(stat_ok), se(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
